mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width (depth 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra access wait states (legal range 0..15).
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1, initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_be, input, 4, byte enables for the store; bit i selects byte lane i.
REQ-009 SHALL have port req_addr, input, ADDR_W, word address.
REQ-010 SHALL have port req_wdata, input, 32, store data, lane-aligned.
REQ-011 SHALL have port rsp_valid, output, 1, response available.
REQ-012 SHALL have port rsp_ready, input, 1, initiator consumes the response.
REQ-013 SHALL have port rsp_rdata, output, 32, load word, or merged word after a store.
REQ-014 SHALL have port rsp_err, output, 1, illegal byte-enable flag; present only with MEM_RESPONDER_BE_CHK_EN.

Function
REQ-015 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-016 SHALL drive req_ready = 1 only in IDLE; a request is accepted in a cycle where req_valid && req_ready.
REQ-017 SHALL latch req_we, req_be, req_addr and req_wdata on the acceptance edge; later input changes are ignored.
REQ-018 SHALL clear the wait counter to 0 on acceptance and increment it once per BUSY cycle.
REQ-019 SHALL perform the memory access on the BUSY edge where counter == WAIT_CYCLES, then enter RESP.
REQ-020 Latency: for a request accepted in cycle N, rsp_valid SHALL first be high in cycle N+2+WAIT_CYCLES (cycle N+4 at the default).
REQ-021 A store SHALL update only the byte lanes with req_be set; rsp_rdata SHALL equal the resulting word.
REQ-022 A store with req_be = 0000 SHALL leave memory unchanged and still produce a response.
REQ-023 A load SHALL return the full word; req_be SHALL be ignored.
REQ-024 In RESP, rsp_valid and rsp_rdata SHALL stay stable until rsp_ready is high; the FSM SHALL return to IDLE on that edge.
REQ-025 req_ready SHALL be low in the RESP handshake cycle, so the next acceptance is no earlier than the following cycle.
REQ-026 rsp_ready outside RESP SHALL have no effect.

Reset
REQ-027 rst low SHALL immediately force the FSM to IDLE, clear the counter, and set rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; req_ready SHALL be 1 after reset.
REQ-028 The memory array SHALL NOT be reset.
REQ-029 A reset asserted in BUSY before the access edge SHALL cancel the store; memory SHALL be unchanged.

Configuration
REQ-030 With MEM_RESPONDER_BE_CHK_EN defined:
- A store whose req_be is not one of 0001, 0010, 0100, 1000, 0011, 1100 or 1111 SHALL leave memory unchanged.
- That store SHALL still respond, with rsp_err = 1 held for the whole RESP phase.
- rsp_err SHALL be 0 in all other cases.
REQ-031 Without MEM_RESPONDER_BE_CHK_EN, port rsp_err and all checking logic SHALL be absent, and every req_be pattern SHALL be written as given.

Structure
REQ-032 Package mem_responder_pkg SHALL hold:
- the FSM state encoding;
- WAIT counter width constant (4 bits);
- the legal byte-enable pattern constants.
REQ-033 Sub-module mem_responder_bank SHALL hold the word array, with a registered byte-enable write and a read port; the parent owns the FSM and the handshake.

Verification
REQ-034 After reset, load addr 0x005 with WAIT_CYCLES=2:
- rsp_valid SHALL first be high 4 cycles after acceptance;
- rsp_rdata SHALL equal the preloaded 0xDEADBEEF.
REQ-035 Start from word 0x11223344. Store be=0100, wdata=0x00AB0000 -> rsp_rdata = 0x11AB3344; a following load returns 0x11AB3344.
REQ-036 Hold rsp_ready low for 5 RESP cycles:
- rsp_valid and rsp_rdata SHALL be stable throughout;
- req_ready SHALL be 0 throughout;
- a req_valid held high is accepted only in the cycle after the handshake.
REQ-037 Assert rst in the first BUSY cycle of a store of 0xFFFFFFFF, be=1111, to a word holding 0x0 -> after reset, a load returns 0x0 and rsp_valid is 0 during reset.
REQ-038 With MEM_RESPONDER_BE_CHK_EN, store be=0101 to a word holding 0xCAFEF00D -> rsp_err = 1 and the word stays 0xCAFEF00D. Without the macro, the same store writes lanes 0 and 2.
REQ-039 With WAIT_CYCLES=0, run back-to-back loads with rsp_ready tied high -> each response arrives 2 cycles after acceptance, and one request completes every 3 cycles.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared types and constants for the memory responder.
//   - FSM state encoding
//   - wait counter width
//   - legal byte-enable patterns and their check function
//   - latched request payload struct
package mem_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Byte, half-word and full-word aligned enables
    localparam logic [BE_W-1:0] BE_LANE0   = 4'b0001;
    localparam logic [BE_W-1:0] BE_LANE1   = 4'b0010;
    localparam logic [BE_W-1:0] BE_LANE2   = 4'b0100;
    localparam logic [BE_W-1:0] BE_LANE3   = 4'b1000;
    localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

    typedef struct packed {
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } req_t;

    function automatic logic be_legal(input logic [BE_W-1:0] be);
        logic ok;
        ok = 1'b0;
        if (be == BE_LANE0 || be == BE_LANE1 || be == BE_LANE2 || be == BE_LANE3 ||
            be == BE_HALF_LO || be == BE_HALF_HI || be == BE_WORD) begin
            ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bus between an initiator and mem_responder.
//   master: initiator side (drives req_*, rsp_ready)
//   slave : responder side (drives req_ready, rsp_*)
//   rsp_err exists only when MEM_RESPONDER_BE_CHK_EN is defined.
interface mem_responder_if #(
    parameter int unsigned ADDR_W = 10
);
    import mem_responder_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [BE_W-1:0]   req_be;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

`ifdef MEM_RESPONDER_BE_CHK_EN
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
`else
    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
`endif

endinterface

// File: rtl/mem_responder_bank.sv
// mem_responder_bank: 2^ADDR_W x 32-bit word array, byte-enable write, async read.
//   clk     : write clock
//   we      : write strobe (already qualified by the parent)
//   be      : byte lanes to update
//   addr    : word address shared by read and write
//   wdata   : lane-aligned write data
//   rdata_c : current contents of addr (combinational)
// The array is intentionally not reset.
module mem_responder_bank
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [BE_W-1:0]   be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Per-lane write
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (be[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with programmable wait states.
//   clk   : clock
//   rst   : asynchronous active-low reset
//   bus   : mem_responder_if.slave (request accept, response with rsp_ready backpressure)
// Optional macro MEM_RESPONDER_BE_CHK_EN: rejects stores with non-aligned byte
// enables (memory untouched, rsp_err raised for the response).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rdy_q, rdy_d;
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] word_c;
    logic [DATA_W-1:0] merged_c;
    logic              wr_ok_c;
    logic              access_c;
    logic              bank_we_c;

`ifdef MEM_RESPONDER_BE_CHK_EN
    logic err_q, err_d;
    assign wr_ok_c     = be_legal(req_q.be);
    assign bus.rsp_err = err_q;
`else
    assign wr_ok_c = 1'b1;
`endif

    assign bank_we_c = access_c & req_q.we & wr_ok_c;

    mem_responder_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .we      (bank_we_c),
        .be      (req_q.be),
        .addr    (addr_q),
        .wdata   (req_q.wdata),
        .rdata_c (word_c)
    );

    // Word as it will look after the store, reported in the response
    always_comb begin
        merged_c = word_c;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (req_q.be[i]) begin
                merged_c[i*8 +: 8] = req_q.wdata[i*8 +: 8];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        addr_d   = addr_q;
        vld_d    = vld_q;
        rdata_d  = rdata_q;
        access_c = 1'b0;
`ifdef MEM_RESPONDER_BE_CHK_EN
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && rdy_q) begin
                    state_d = ST_BUSY;
                    cnt_d   = '0;
                    req_d   = '{we: bus.req_we, be: bus.req_be, wdata: bus.req_wdata};
                    addr_d  = bus.req_addr;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(WAIT_CYCLES)) begin
                    access_c = 1'b1;
                    state_d  = ST_RESP;
                    vld_d    = 1'b1;
                    rdata_d  = (req_q.we && wr_ok_c) ? merged_c : word_c;
`ifdef MEM_RESPONDER_BE_CHK_EN
                    err_d    = req_q.we & ~wr_ok_c;
`endif
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                    vld_d   = 1'b0;
`ifdef MEM_RESPONDER_BE_CHK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        rdy_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            addr_q  <= '0;
            rdy_q   <= 1'b1;
            vld_q   <= 1'b0;
            rdata_q <= '0;
`ifdef MEM_RESPONDER_BE_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            rdy_q   <= rdy_d;
            vld_q   <= vld_d;
            rdata_q <= rdata_d;
`ifdef MEM_RESPONDER_BE_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.req_ready = rdy_q;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed scoreboard bench for mem_responder.
// dut_a runs WAIT_CYCLES=2, dut_b runs WAIT_CYCLES=0 with rsp_ready tied high.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned WA = 2;
    localparam int unsigned WB = 0;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_responder_if #(.ADDR_W(AW)) bus_a ();
    mem_responder_if #(.ADDR_W(AW)) bus_b ();

    mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WA)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WB)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [32:0] exp_a [$];
    logic [31:0] exp_b [$];
    logic [31:0] model [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = wd[i*8 +: 8];
        return r;
    endfunction

`ifdef MEM_RESPONDER_BE_CHK_EN
    function automatic bit be_ok(input logic [3:0] be);
        return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction
`endif

    // Push the expected response, present the request and wait for acceptance
    task automatic send_req(input logic we, input logic [3:0] be, input logic [9:0] addr,
                            input logic [31:0] wd, output int n);
        logic [31:0] old, res;
        logic        err;
        old = model.exists(int'(addr)) ? model[int'(addr)] : 32'h0;
        err = 1'b0;
        res = we ? merge(old, wd, be) : old;
`ifdef MEM_RESPONDER_BE_CHK_EN
        if (we && !be_ok(be)) begin
            err = 1'b1;
            res = old;
        end
`endif
        if (we) model[int'(addr)] = res;
        exp_a.push_back({err, res});
        bus_a.req_we    = we;
        bus_a.req_be    = be;
        bus_a.req_addr  = addr;
        bus_a.req_wdata = wd;
        bus_a.req_valid = 1'b1;
        n = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus_a.req_ready) begin
                n = cyc;
                break;
            end
            @(negedge clk);
        end
        check("accept", 32'(n >= 0), 32'd1);
        @(posedge clk);
        #1;
        // Scramble inputs after acceptance; the DUT must use its latched copy
        bus_a.req_valid = 1'b0;
        bus_a.req_we    = ~we;
        bus_a.req_be    = ~be;
        bus_a.req_addr  = ~addr;
        bus_a.req_wdata = ~wd;
    endtask

    task automatic wait_rsp(input int n, output int m);
        logic [32:0] e;
        m = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_a.rsp_valid) begin
                m = cyc;
                break;
            end
        end
        check("latency", 32'(m - n), 32'(2 + WA));
        e = (exp_a.size() > 0) ? exp_a.pop_front() : 33'bx;
        check("rdata", bus_a.rsp_rdata, e[31:0]);
`ifdef MEM_RESPONDER_BE_CHK_EN
        check("rsp_err", 32'(bus_a.rsp_err), 32'(e[32]));
`endif
    endtask

    task automatic release_rsp();
        bus_a.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_a.rsp_ready = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bus_a.req_ready), 32'd1);
        check("rsp_drop", 32'(bus_a.rsp_valid), 32'd0);
    endtask

    task automatic xact(input logic we, input logic [3:0] be, input logic [9:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd);
        int n, m;
        send_req(we, be, addr, wd, n);
        wait_rsp(n, m);
        rd = bus_a.rsp_rdata;
        release_rsp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, r0;
        int          n, m, h, prev;
        logic [31:0] sd [3];

        rst = 1'b0;
        bus_a.req_valid = 1'b0; bus_a.req_we = 1'b0; bus_a.req_be = '0;
        bus_a.req_addr = '0; bus_a.req_wdata = '0; bus_a.rsp_ready = 1'b0;
        bus_b.req_valid = 1'b0; bus_b.req_we = 1'b0; bus_b.req_be = '0;
        bus_b.req_addr = '0; bus_b.req_wdata = '0; bus_b.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready_a", 32'(bus_a.req_ready), 32'd1);
        check("rst_valid_a", 32'(bus_a.rsp_valid), 32'd0);
        check("rst_rdata_a", bus_a.rsp_rdata, 32'h0);
        check("rst_ready_b", 32'(bus_b.req_ready), 32'd1);
        rst = 1'b1;
        @(negedge clk);

        // Preload, reset (array keeps contents), then load with latency check
        xact(1'b1, 4'b1111, 10'h005, 32'hDEADBEEF, rd);
        rst = 1'b0;
        #1;
        check("rst_async_ready", 32'(bus_a.req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        xact(1'b0, 4'b0000, 10'h005, 32'h0, rd);
        check("load_deadbeef", rd, 32'hDEADBEEF);

        // Single-lane store and readback
        xact(1'b1, 4'b1111, 10'h031, 32'h11223344, rd);
        xact(1'b1, 4'b0100, 10'h031, 32'h00AB0000, rd);
        check("store_be0100", rd, 32'h11AB3344);
        xact(1'b0, 4'b1010, 10'h031, 32'h0, rd);
        check("load_be0100", rd, 32'h11AB3344);

        // Backpressure: response held 5 cycles with a queued request
        xact(1'b1, 4'b1111, 10'h040, 32'h55AA55AA, rd);
        xact(1'b1, 4'b1111, 10'h041, 32'h0BADCAFE, rd);
        send_req(1'b0, 4'b0000, 10'h040, 32'h0, n);
        wait_rsp(n, m);
        r0 = bus_a.rsp_rdata;
        bus_a.req_we = 1'b0; bus_a.req_be = 4'b0000;
        bus_a.req_addr = 10'h041; bus_a.req_wdata = 32'h0;
        bus_a.req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("hold_valid", 32'(bus_a.rsp_valid), 32'd1);
            check("hold_rdata", bus_a.rsp_rdata, r0);
            check("hold_ready", 32'(bus_a.req_ready), 32'd0);
        end
        h = cyc;
        release_rsp();
        send_req(1'b0, 4'b0000, 10'h041, 32'h0, n);
        check("accept_after_hs", 32'(n - h), 32'd1);
        wait_rsp(n, m);
        release_rsp();

        // Non-aligned byte enables
        xact(1'b1, 4'b1111, 10'h050, 32'hCAFEF00D, rd);
        xact(1'b1, 4'b0101, 10'h050, 32'h11223344, rd);
`ifdef MEM_RESPONDER_BE_CHK_EN
        check("be0101_rsp", rd, 32'hCAFEF00D);
`else
        check("be0101_rsp", rd, 32'hCA22F044);
`endif
        xact(1'b0, 4'b0000, 10'h050, 32'h0, rd);
        // Empty byte enable leaves the word alone
        xact(1'b1, 4'b0000, 10'h050, 32'hFFFFFFFF, rd);
        xact(1'b0, 4'b1111, 10'h050, 32'h0, rd);

        // Reset in the first BUSY cycle cancels the store
        xact(1'b1, 4'b1111, 10'h060, 32'h0, rd);
        bus_a.req_we = 1'b1; bus_a.req_be = 4'b1111;
        bus_a.req_addr = 10'h060; bus_a.req_wdata = 32'hFFFFFFFF;
        bus_a.req_valid = 1'b1;
        check("busy_acc_ready", 32'(bus_a.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        check("busy_entered", 32'(bus_a.req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_busy_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("rst_busy_ready", 32'(bus_a.req_ready), 32'd1);
        repeat (2) @(negedge clk);
        check("rst_hold_valid", 32'(bus_a.rsp_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        xact(1'b0, 4'b0000, 10'h060, 32'h0, rd);
        check("store_cancelled", rd, 32'h0);

        // Zero-wait back-to-back stream on dut_b
        prev = -1;
        for (int i = 0; i < 6; i++) begin
            bus_b.req_we    = (i < 3);
            bus_b.req_be    = 4'b1111;
            bus_b.req_addr  = 10'(10'h100 + (i % 3));
            if (i < 3) begin
                sd[i] = 32'hA5000000 + 32'(i) * 32'h01010111;
                bus_b.req_wdata = sd[i];
                exp_b.push_back(sd[i]);
            end else begin
                bus_b.req_wdata = 32'h0;
                exp_b.push_back(sd[i % 3]);
            end
            bus_b.req_valid = 1'b1;
            n = -1;
            for (int k = 0; k < 10; k++) begin
                if (bus_b.req_ready) begin
                    n = cyc;
                    break;
                end
                @(negedge clk);
            end
            if (i > 0) check("b_rate", 32'(n - prev), 32'd3);
            prev = n;
            @(negedge clk);
            check("b_busy", 32'(bus_b.rsp_valid), 32'd0);
            @(negedge clk);
            check("b_latency", 32'(bus_b.rsp_valid), 32'd1);
            check("b_rdata", bus_b.rsp_rdata, exp_b.pop_front());
        end
        bus_b.req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
